// File: rtl/rom_req_arbiter.sv
// Shares one ROM command/response byte-FIFO pair between two requesters, one whole command packet at a time, round-robin.
// Latency: a grant takes one idle cycle and command bytes then pass straight through; each response byte takes 3 cycles, FIFO pop to rsp valid.
// Backpressure: cmd_almost_full stalls the granted requester, and a full tag queue blocks new grants; a held response byte waits for rspN_ready.
module rom_req_arbiter #(
    parameter int CMD_LEN = 8,
    parameter int RSP_LEN = 8,
    parameter int OUTST   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_data,
    input  logic       rsp0_ready,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_data,
    input  logic       rsp1_ready,
    input  logic       cmd_almost_full,
    output logic       cmd_wr_en,
    output logic [7:0] cmd_dout,
    input  logic       res_almost_empty,
    output logic       res_rd_en,
    input  logic [7:0] res_din
);

    localparam int CW = $clog2(CMD_LEN + 1);
    localparam int RW = $clog2(RSP_LEN + 1);
    localparam int PW = $clog2(OUTST);

    typedef enum logic {C_IDLE, C_BUSY} cmd_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_HOLD} rsp_state_t;

    cmd_state_t cmd_state, cmd_state_nxt;
    rsp_state_t rsp_state, rsp_state_nxt;

    logic          gnt;
    logic          rr;
    logic [CW-1:0] byte_cnt;
    logic          grant;
    logic          grant_sel;
    logic          last_byte;

    logic [OUTST-1:0] tq_mem;
    logic [PW-1:0]    tq_wr;
    logic [PW-1:0]    tq_rd;
    logic [PW:0]      tq_cnt;
    logic             tq_full;
    logic             tq_empty;
    logic             tq_head;
    logic             tq_pop;

    logic [RW-1:0] rsp_cnt;
    logic [7:0]    hold_dat;
    logic          rsp_accept;

    assign tq_full  = (tq_cnt == (PW+1)'(OUTST));
    assign tq_empty = (tq_cnt == '0);
    assign tq_head  = tq_mem[tq_rd];

    // rr names the preferred requester; the other one wins only when the preferred one is idle
    assign grant_sel = rr ? req1_valid : !req0_valid;
    assign grant     = (cmd_state == C_IDLE) && !tq_full && (req0_valid || req1_valid);
    assign last_byte = cmd_wr_en && (byte_cnt == CW'(CMD_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmd_state <= C_IDLE;
        else     cmd_state <= cmd_state_nxt;
    end

    always_comb begin
        cmd_state_nxt = cmd_state;
        case (cmd_state)
            C_IDLE:  if (grant) cmd_state_nxt = C_BUSY;
            C_BUSY:  if (last_byte) cmd_state_nxt = C_IDLE;
            default: cmd_state_nxt = C_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        cmd_wr_en  = 1'b0;
        cmd_dout   = 8'h00;
        if (cmd_state == C_BUSY) begin
            req0_ready = !gnt && !cmd_almost_full;
            req1_ready = gnt && !cmd_almost_full;
            cmd_wr_en  = (gnt ? req1_valid : req0_valid) && !cmd_almost_full;
            if (cmd_wr_en) cmd_dout = gnt ? req1_data : req0_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt      <= 1'b0;
            rr       <= 1'b0;
            byte_cnt <= '0;
        end else if (grant) begin
            gnt      <= grant_sel;
            byte_cnt <= '0;
        end else if (cmd_wr_en) begin
            byte_cnt <= byte_cnt + CW'(1);
            if (last_byte) rr <= !gnt;
        end
    end

    // Tag queue: one entry per granted packet, popped after its last response byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tq_mem <= '0;
            tq_wr  <= '0;
            tq_rd  <= '0;
            tq_cnt <= '0;
        end else begin
            if (grant) begin
                tq_mem[tq_wr] <= grant_sel;
                tq_wr         <= tq_wr + PW'(1);
            end
            if (tq_pop) tq_rd <= tq_rd + PW'(1);
            if (grant && !tq_pop)      tq_cnt <= tq_cnt + (PW+1)'(1);
            else if (!grant && tq_pop) tq_cnt <= tq_cnt - (PW+1)'(1);
        end
    end

    assign rsp_accept = (rsp_state == R_HOLD) && (tq_head ? rsp1_ready : rsp0_ready);
    assign tq_pop     = rsp_accept && (rsp_cnt == RW'(RSP_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rsp_state <= R_IDLE;
        else     rsp_state <= rsp_state_nxt;
    end

    always_comb begin
        rsp_state_nxt = rsp_state;
        case (rsp_state)
            R_IDLE:  if (!tq_empty && !res_almost_empty) rsp_state_nxt = R_WAIT;
            R_WAIT:  rsp_state_nxt = R_HOLD;
            R_HOLD:  if (rsp_accept) rsp_state_nxt = R_IDLE;
            default: rsp_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        res_rd_en  = (rsp_state == R_IDLE) && !tq_empty && !res_almost_empty;
        rsp0_valid = (rsp_state == R_HOLD) && !tq_head;
        rsp1_valid = (rsp_state == R_HOLD) && tq_head;
        rsp0_data  = hold_dat;
        rsp1_data  = hold_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_dat <= 8'h00;
            rsp_cnt  <= '0;
        end else begin
            if (rsp_state == R_WAIT) hold_dat <= res_din;
            if (tq_pop)          rsp_cnt <= '0;
            else if (rsp_accept) rsp_cnt <= rsp_cnt + RW'(1);
        end
    end

endmodule

// File: tb/tb_rom_req_arbiter.sv
// Randomized bench for rom_req_arbiter: requesters, command FIFO and response FIFO are modelled
// as queues; packet order, routing and round-robin are predicted at packet level.
module tb_rom_req_arbiter;

    localparam int CMD_LEN = 8;
    localparam int RSP_LEN = 8;
    localparam int OUTST   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0] req0_data, req1_data;
    logic       rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [7:0] rsp0_data, rsp1_data;
    logic       cmd_almost_full, cmd_wr_en, res_almost_empty, res_rd_en;
    logic [7:0] cmd_dout, res_din;

    rom_req_arbiter #(.CMD_LEN(CMD_LEN), .RSP_LEN(RSP_LEN), .OUTST(OUTST)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .cmd_almost_full(cmd_almost_full), .cmd_wr_en(cmd_wr_en), .cmd_dout(cmd_dout),
        .res_almost_empty(res_almost_empty), .res_rd_en(res_rd_en), .res_din(res_din)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] q0[$], q1[$], exp0[$], exp1[$], rom_q[$], defer_q[$];
    logic [7:0] res_din_nxt;
    int  seq0, seq1, rsp_seq;
    bit  rr_m, strict, throttle, rom_hold;
    int  af_pct, rdy_pct;
    int  cur_cnt, pkts_started, pkts_done, rsp_bytes, rsp_pkts, cyc;
    bit  cur_src, last_pkt_src;
    int  first_wr_cyc, last_wr_cyc;
    bit  prev_hold, prev_src;
    logic [7:0] prev_dat;

    task automatic add_pkt(input bit src);
        for (int i = 0; i < CMD_LEN; i++) begin
            if (src) q1.push_back({1'b1, 4'(seq1), 3'(i)});
            else     q0.push_back({1'b0, 4'(seq0), 3'(i)});
        end
        if (src) seq1++; else seq0++;
    endtask

    task automatic cycle();
        bit src, exp_src;
        logic [7:0] expb, rb;
        req0_valid       = (q0.size() > 0) && (!throttle || $urandom_range(3) != 0);
        req0_data        = (q0.size() > 0) ? q0[0] : 8'h00;
        req1_valid       = (q1.size() > 0) && (!throttle || $urandom_range(3) != 0);
        req1_data        = (q1.size() > 0) ? q1[0] : 8'h00;
        cmd_almost_full  = ($urandom_range(99) < af_pct);
        rsp0_ready       = ($urandom_range(99) < rdy_pct);
        rsp1_ready       = ($urandom_range(99) < rdy_pct);
        res_almost_empty = (rom_q.size() == 0);
        res_din          = res_din_nxt;
        #1;
        check("two_ready", 32'(req0_ready & req1_ready), 0);
        check("af_block", 32'((req0_ready | req1_ready) & cmd_almost_full), 0);
        check("wr_en", 32'(cmd_wr_en), 32'((req0_valid & req0_ready) | (req1_valid & req1_ready)));
        if (cmd_wr_en) begin
            src = req1_valid & req1_ready;
            if (cur_cnt == 0) begin
                if (strict) begin
                    exp_src = rr_m ? (q1.size() > 0) : !(q0.size() > 0);
                    check("rr_order", 32'(src), 32'(exp_src));
                end
                cur_src = src;
                pkts_started++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end else begin
                check("no_interleave", 32'(src), 32'(cur_src));
            end
            if ((src ? q1.size() : q0.size()) == 0) begin
                check("cmd_src_empty", 1, 0);
            end else begin
                expb = src ? q1.pop_front() : q0.pop_front();
                check("cmd_dout", 32'(cmd_dout), 32'(expb));
            end
            cur_cnt++;
            last_wr_cyc = cyc;
            if (cur_cnt == CMD_LEN) begin
                cur_cnt      = 0;
                rr_m         = !src;
                last_pkt_src = src;
                pkts_done++;
                for (int i = 0; i < RSP_LEN; i++) begin
                    rb = {src, 7'(rsp_seq)};
                    rsp_seq++;
                    if (src) exp1.push_back(rb); else exp0.push_back(rb);
                    if (rom_hold) defer_q.push_back(rb); else rom_q.push_back(rb);
                end
            end
        end
        check("rsp_both", 32'(rsp0_valid & rsp1_valid), 0);
        check("rd_while_empty", 32'(res_rd_en & res_almost_empty), 0);
        check("rd_while_hold", 32'(res_rd_en & (rsp0_valid | rsp1_valid)), 0);
        check("rsp0_spurious", 32'(rsp0_valid && exp0.size() == 0), 0);
        check("rsp1_spurious", 32'(rsp1_valid && exp1.size() == 0), 0);
        if (prev_hold)
            check("hold_stable", prev_src ? {23'd0, rsp1_valid, rsp1_data} : {23'd0, rsp0_valid, rsp0_data},
                  {23'd0, 1'b1, prev_dat});
        prev_hold = 1'b0;
        if (rsp0_valid && !rsp0_ready) begin prev_hold = 1'b1; prev_src = 1'b0; prev_dat = rsp0_data; end
        if (rsp1_valid && !rsp1_ready) begin prev_hold = 1'b1; prev_src = 1'b1; prev_dat = rsp1_data; end
        if (rsp0_valid && rsp0_ready && exp0.size() > 0) begin
            check("rsp0_dat", 32'(rsp0_data), 32'(exp0.pop_front()));
            rsp_bytes++;
            if (rsp_bytes % RSP_LEN == 0) rsp_pkts++;
        end
        if (rsp1_valid && rsp1_ready && exp1.size() > 0) begin
            check("rsp1_dat", 32'(rsp1_data), 32'(exp1.pop_front()));
            rsp_bytes++;
            if (rsp_bytes % RSP_LEN == 0) rsp_pkts++;
        end
        check("outstanding", 32'(pkts_started > rsp_pkts + OUTST), 0);
        if (res_rd_en && rom_q.size() > 0) res_din_nxt = rom_q.pop_front();
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((q0.size() + q1.size() + exp0.size() + exp1.size() + rom_q.size() + cur_cnt) != 0
               && k < budget) begin
            cycle();
            k++;
        end
        check("drain_timeout", 32'(k >= budget), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_outs", {3'd0, req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
                           cmd_wr_en, cmd_dout, res_rd_en}, 0);
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete(); rom_q.delete(); defer_q.delete();
        cur_cnt = 0; rr_m = 1'b0; prev_hold = 1'b0; res_din_nxt = 8'h00;
        pkts_started = 0; pkts_done = 0; rsp_bytes = 0; rsp_pkts = 0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0; cmd_almost_full = 1'b0;
        res_almost_empty = 1'b1; res_din = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int base, pk, t_pop, t_gnt;
        seq0 = 0; seq1 = 0; rsp_seq = 0; rom_hold = 1'b0;
        strict = 1'b1; throttle = 1'b0; af_pct = 0; rdy_pct = 100;
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'h10; req1_data = 8'h20;
        cmd_almost_full = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        res_almost_empty = 1'b0; res_din = 8'h00;
        #2;
        do_reset();

        // single req0 packet: first byte one cycle after grant, eight bytes back to back
        cyc = 0; first_wr_cyc = -1;
        add_pkt(1'b0);
        run(12);
        check("t1_first_wr", 32'(first_wr_cyc), 1);
        check("t1_last_wr", 32'(last_wr_cyc), 8);
        drain(400);

        // five req1 packets with responses withheld: four granted, fifth waits for the first pop
        rom_hold = 1'b1;
        base = pkts_started;
        for (int i = 0; i < 5; i++) add_pkt(1'b1);
        run(80);
        check("t4_granted", 32'(pkts_started - base), 4);
        check("t4_held", 32'(q1.size()), CMD_LEN);
        rom_hold = 1'b0;
        while (defer_q.size() > 0) rom_q.push_back(defer_q.pop_front());
        pk = rsp_pkts; t_pop = -1; t_gnt = -1;
        for (int i = 0; i < 400 && t_gnt < 0; i++) begin
            cycle();
            if (t_pop < 0 && rsp_pkts > pk) t_pop = cyc - 1;
            if (t_gnt < 0 && pkts_started > base + 4) t_gnt = cyc - 1;
        end
        check("t4_grant_after_pop", 32'(t_gnt - t_pop), 2);
        drain(1500);

        // reset while byte 4 of a req0 packet is on the bus, then a fresh req1 packet
        add_pkt(1'b0);
        for (int i = 0; i < 30 && cur_cnt < 3; i++) cycle();
        check("t6_reached_byte3", 32'(cur_cnt), 3);
        check("t6_byte4_live", 32'(cmd_wr_en), 1);
        do_reset();
        cyc = 0; first_wr_cyc = -1;
        add_pkt(1'b1);
        run(12);
        check("t6_first_wr", 32'(first_wr_cyc), 1);
        check("t6_last_wr", 32'(last_wr_cyc), 8);
        check("t6_src", 32'(last_pkt_src), 1);
        drain(400);

        // both requesters always pending: strict alternation starting with req0
        do_reset();
        strict = 1'b1; throttle = 1'b0; af_pct = 30; rdy_pct = 60;
        for (int i = 0; i < 6; i++) begin add_pkt(1'b0); add_pkt(1'b1); end
        drain(6000);
        check("phaseA_pkts", 32'(pkts_done), 12);

        // throttled valids with random backpressure everywhere
        strict = 1'b0; throttle = 1'b1; af_pct = 20; rdy_pct = 50;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < $urandom_range(4, 1); i++) add_pkt(1'b0);
            for (int i = 0; i < $urandom_range(4); i++) add_pkt(1'b1);
            drain(8000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
